fifo_control_ram: RTL and testbench

//  Single-clock synchronous FIFO: pointer/flag controller plus a two-port RAM (one write port, one read port).

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/fifo_dpram.sv | 28 ++
 rtl/fifo_control_ram.sv | 152 +++++++++++++++
 tb/tb_fifo_control_ram.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and flag-decode helpers for the synchronous FIFO (fifo_control_ram).
package fifo_pkg;

    localparam int FIFO_ADDR_LENGTH = 8;
    localparam int FIFO_DATA_WIDTH  = 65;
    localparam int FIFO_AE_LEVEL    = 4;
    localparam int FIFO_AF_LEVEL    = 252;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic half_full;
        logic almost_full;
        logic full;
    } fifo_flags_t;

    // Decode all status flags from an occupancy value; all operands are 32-bit.
    function automatic fifo_flags_t count_to_flags(
        input logic [31:0] cnt,
        input logic [31:0] depth,
        input logic [31:0] ae_level,
        input logic [31:0] af_level
    );
        fifo_flags_t f;
        f.empty        = (cnt == 32'd0);
        f.almost_empty = (cnt <= ae_level);
        f.half_full    = (cnt >= (depth >> 1));
        f.almost_full  = (cnt >= af_level);
        f.full         = (cnt == depth);
        return f;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Two-port RAM: one synchronous write port and one registered read port.
// Read returns the pre-write contents on an address collision; callers forward if needed.
module fifo_dpram #(
    parameter int aw = 8,
    parameter int dw = 65
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [aw-1:0] waddr_i,
    input  logic [dw-1:0] wdata_i,
    input  logic [aw-1:0] raddr_i,
    output logic [dw-1:0] rdata_o
);

    logic [dw-1:0] mem_q [2**aw];
    logic [dw-1:0] rdata_q;

    // Storage write and registered read of the requested address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_control_ram.sv
// First-word-fall-through synchronous FIFO: pointers, occupancy, flags, allow logic,
// write-through forwarding into the head register, and the backing fifo_dpram.
// Optional error reporting (sticky overflow/underflow ports) with FIFO_CONTROL_ERR_EN.
module fifo_control_ram
    import fifo_pkg::*;
#(
    parameter int ADDR_LENGTH = FIFO_ADDR_LENGTH,
    parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
    parameter int AE_LEVEL    = FIFO_AE_LEVEL,
    parameter int AF_LEVEL    = FIFO_AF_LEVEL
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   clear_in,
    input  logic                   wenable_in,
    input  logic [DATA_WIDTH-1:0]  wdata_in,
    input  logic                   renable_in,
    output logic [DATA_WIDTH-1:0]  rdata_out,
    output logic                   wallow_out,
    output logic                   rallow_out,
    output logic                   empty_out,
    output logic                   full_out,
    output logic                   almost_empty_out,
    output logic                   almost_full_out,
    output logic                   half_full_out,
    output logic [ADDR_LENGTH-1:0] waddr_out,
    output logic [ADDR_LENGTH-1:0] raddr_out,
    output logic [ADDR_LENGTH:0]   count_out
`ifdef FIFO_CONTROL_ERR_EN
    ,
    output logic                   overflow_out,
    output logic                   underflow_out
`endif
);

    localparam int DEPTH = 2**ADDR_LENGTH;
    localparam logic [ADDR_LENGTH-1:0] PTR_ONE = {{(ADDR_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_LENGTH:0]   CNT_ONE = {{ADDR_LENGTH{1'b0}}, 1'b1};

    logic [ADDR_LENGTH-1:0] waddr_q, waddr_d;
    logic [ADDR_LENGTH-1:0] raddr_q, raddr_d;
    logic [ADDR_LENGTH:0]   count_q, count_d;
    logic                   fwd_sel_q, fwd_sel_d;
    logic [DATA_WIDTH-1:0]  fwd_data_q, fwd_data_d;
    logic                   wallow_s, rallow_s, ram_we_s;
    logic [DATA_WIDTH-1:0]  ram_rdata_s;
    fifo_flags_t            flags_s;

    assign flags_s = count_to_flags(32'(count_q), 32'(DEPTH), 32'(AE_LEVEL), 32'(AF_LEVEL));

    // Accept/advance decisions and next-state for pointers, count and head forwarding.
    always_comb begin
        wallow_s   = wenable_in & ~flags_s.full;
        rallow_s   = renable_in & ~flags_s.empty;
        ram_we_s   = wallow_s & ~clear_in;
        waddr_d    = waddr_q;
        raddr_d    = raddr_q;
        count_d    = count_q;
        fwd_sel_d  = 1'b0;
        fwd_data_d = wdata_in;
        if (clear_in) begin
            waddr_d    = '0;
            raddr_d    = '0;
            count_d    = '0;
            fwd_sel_d  = 1'b1;
            fwd_data_d = '0;
        end else begin
            if (wallow_s) begin
                waddr_d = waddr_q + PTR_ONE;
            end else begin
                waddr_d = waddr_q;
            end
            if (rallow_s) begin
                raddr_d = raddr_q + PTR_ONE;
            end else begin
                raddr_d = raddr_q;
            end
            if (wallow_s && !rallow_s) begin
                count_d = count_q + CNT_ONE;
            end else if (rallow_s && !wallow_s) begin
                count_d = count_q - CNT_ONE;
            end else begin
                count_d = count_q;
            end
            // A write landing on the next head slot bypasses the RAM's stale read.
            fwd_sel_d = wallow_s && (waddr_q == raddr_d);
        end
    end

    // Pointer, count and forwarding registers; reset forces the head output to zero.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            waddr_q    <= '0;
            raddr_q    <= '0;
            count_q    <= '0;
            fwd_sel_q  <= 1'b1;
            fwd_data_q <= '0;
        end else begin
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            count_q    <= count_d;
            fwd_sel_q  <= fwd_sel_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    fifo_dpram #(
        .aw (ADDR_LENGTH),
        .dw (DATA_WIDTH)
    ) u_ram (
        .clk_i   (wb_clk_i),
        .we_i    (ram_we_s),
        .waddr_i (waddr_q),
        .wdata_i (wdata_in),
        .raddr_i (raddr_d),
        .rdata_o (ram_rdata_s)
    );

    assign rdata_out        = fwd_sel_q ? fwd_data_q : ram_rdata_s;
    assign wallow_out       = wallow_s;
    assign rallow_out       = rallow_s;
    assign empty_out        = flags_s.empty;
    assign full_out         = flags_s.full;
    assign almost_empty_out = flags_s.almost_empty;
    assign almost_full_out  = flags_s.almost_full;
    assign half_full_out    = flags_s.half_full;
    assign waddr_out        = waddr_q;
    assign raddr_out        = raddr_q;
    assign count_out        = count_q;

`ifdef FIFO_CONTROL_ERR_EN
    logic overflow_q, underflow_q;

    // Sticky records of writes attempted while full and reads attempted while empty.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear_in) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (wenable_in & flags_s.full);
            underflow_q <= underflow_q | (renable_in & flags_s.empty);
        end
    end

    assign overflow_out  = overflow_q;
    assign underflow_out = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_control_ram.sv
// Scoreboard bench for fifo_control_ram: a queue models FIFO contents and every
// cycle checks allows, head data, count and flags against that model.
module tb_fifo_control_ram;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [64:0]  wd = 65'd0;
    logic [64:0]  rdata;
    logic         wallow, rallow, empty, full, aempty, afull, hfull;
    logic [7:0]   waddr, raddr;
    logic [8:0]   count;
`ifdef FIFO_CONTROL_ERR_EN
    logic         ovf, unf;
    logic         ovf_m = 1'b0;
    logic         unf_m = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [64:0] sb_q [$];

    fifo_control_ram dut (
        .wb_clk_i         (wb_clk_dummy()),
        .wb_rst_i         (rst_n),
        .clear_in         (clear),
        .wenable_in       (we),
        .wdata_in         (wd),
        .renable_in       (re),
        .rdata_out        (rdata),
        .wallow_out       (wallow),
        .rallow_out       (rallow),
        .empty_out        (empty),
        .full_out         (full),
        .almost_empty_out (aempty),
        .almost_full_out  (afull),
        .half_full_out    (hfull),
        .waddr_out        (waddr),
        .raddr_out        (raddr),
        .count_out        (count)
`ifdef FIFO_CONTROL_ERR_EN
        ,
        .overflow_out     (ovf),
        .underflow_out    (unf)
`endif
    );

    function automatic logic wb_clk_dummy();
        return clk;
    endfunction

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        int n;
        n = sb_q.size();
        chk("count", 65'(count), 65'(n));
        chk("empty", 65'(empty), 65'(n == 0));
        chk("full", 65'(full), 65'(n == 256));
        chk("almost_empty", 65'(aempty), 65'(n <= 4));
        chk("almost_full", 65'(afull), 65'(n >= 252));
        chk("half_full", 65'(hfull), 65'(n >= 128));
        if (n > 0) chk("head", rdata, sb_q[0]);
`ifdef FIFO_CONTROL_ERR_EN
        chk("overflow", 65'(ovf), 65'(ovf_m));
        chk("underflow", 65'(unf), 65'(unf_m));
`endif
    endtask

    // Called at posedge+1: drive, check allows and the popped word, clock, check state.
    task automatic step(input logic w, input logic [64:0] d, input logic r, input logic c);
        logic ew, er;
        int n;
        we = w; wd = d; re = r; clear = c;
        #1;
        n  = sb_q.size();
        ew = w && (n < 256);
        er = r && (n > 0);
        chk("wallow", 65'(wallow), 65'(ew));
        chk("rallow", 65'(rallow), 65'(er));
        if (er) chk("pop_data", rdata, sb_q[0]);
`ifdef FIFO_CONTROL_ERR_EN
        if (c) begin
            ovf_m = 1'b0; unf_m = 1'b0;
        end else begin
            ovf_m = ovf_m | (w && n == 256);
            unf_m = unf_m | (r && n == 0);
        end
`endif
        @(posedge clk);
        if (c) begin
            sb_q.delete();
        end else begin
            if (er) void'(sb_q.pop_front());
            if (ew) sb_q.push_back(d);
        end
        #1;
        we = 1'b0; re = 1'b0; clear = 1'b0;
        chk_state();
    endtask

    initial begin
        logic [64:0] rd;
        // Reset state while reset is held.
        #3;
        chk_state();
        chk("reset_rdata", rdata, 65'd0);
        chk("reset_waddr", 65'(waddr), 65'd0);
        chk("reset_raddr", 65'(raddr), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 65'd0, 1'b0, 1'b0);

        // Single word, first-word fall-through, then pop back to empty.
        step(1'b1, 65'h1_0000_0000_0000_0001, 1'b0, 1'b0);
        chk("fwft_word", rdata, 65'h1_0000_0000_0000_0001);
        step(1'b0, 65'd0, 1'b1, 1'b0);
        chk("pop_empty", 65'(empty), 65'd1);

        // Fill with 0..255, then one rejected extra write.
        for (int i = 0; i < 256; i++) step(1'b1, 65'(i), 1'b0, 1'b0);
        chk("filled_full", 65'(full), 65'd1);
        step(1'b1, 65'h1_dead_beef_0000_0000, 1'b0, 1'b0);
        chk("overfill_count", 65'(count), 65'd256);

        // Full with read+write: only the read goes.
        step(1'b1, 65'h0_1234, 1'b1, 1'b0);
        chk("full_rw_count", 65'(count), 65'd255);
        while (sb_q.size() > 0) step(1'b0, 65'd0, 1'b1, 1'b0);
        // Read on empty is ignored.
        step(1'b0, 65'd0, 1'b1, 1'b0);
        // Empty with read+write: only the write goes.
        step(1'b1, 65'h1_5555_aaaa_5555_aaaa, 1'b1, 1'b0);
        chk("empty_rw_count", 65'(count), 65'd1);
        step(1'b0, 65'd0, 1'b1, 1'b0);

        // Random stream of 1000 words across several pointer wraps.
        begin
            int sent = 0;
            for (int cyc = 0; cyc < 6000 && sent < 1000; cyc++) begin
                logic w, r;
                rd = {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom)};
                w  = ($urandom_range(0, 3) != 0);
                r  = ($urandom_range(0, 2) != 0);
                if (w && sb_q.size() < 256) sent++;
                step(w, rd, r, 1'b0);
            end
            chk("stream_sent", 65'(sent), 65'd1000);
        end
        while (sb_q.size() > 0) step(1'b0, 65'd0, 1'b1, 1'b0);

        // Synchronous clear at count 100, overriding a same-cycle write/read.
        for (int i = 0; i < 100; i++) step(1'b1, 65'(1000 + i), 1'b0, 1'b0);
        chk("pre_clear_count", 65'(count), 65'd100);
        step(1'b1, 65'h0_7777, 1'b1, 1'b1);
        chk("clear_count", 65'(count), 65'd0);
        chk("clear_rdata", rdata, 65'd0);
        step(1'b1, 65'h1_abcd_0000_ffff_0001, 1'b0, 1'b0);
        step(1'b1, 65'h0_0002, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, checked before the next clock edge.
        for (int i = 0; i < 20; i++) step(1'b1, 65'(2000 + i), 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        sb_q.delete();
`ifdef FIFO_CONTROL_ERR_EN
        ovf_m = 1'b0; unf_m = 1'b0;
`endif
        chk_state();
        chk("async_rdata", rdata, 65'd0);
        chk("async_waddr", 65'(waddr), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 65'h1_0f0f_0f0f_0f0f_0f0f, 1'b0, 1'b0);
        step(1'b0, 65'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
